wormhole_output_allocator: RTL and testbench
============================================

// Module: wormhole_output_allocator
// PURPOSE
//  Per-output-port allocator for the NoC switch. Shares one output channel
//  between IN_N input ports, one packet at a time (wormhole switching).
//  Uses round-robin arbitration and holds the grant from head flit to tail flit.
//  Sits between the input buffers' route requests and the crossbar select.
// PARAMETERS
//  IN_N     5                  number of competing input ports (>=1)
//  GRANT_W  (IN_N>1 ? $clog2(IN_N) : 1)  width of binary grant index; derived, do not override
// PORTS
//  clk_i        in   1        clock
//  rst_i        in   1        synchronous, active-high reset
//  req_i        in   IN_N     input i has a valid flit destined to this output
//  last_i       in   IN_N     flit on input i is a tail flit (qualified by req_i[i])
//  out_rdy_i    in   1        downstream output channel accepts a flit this cycle
//  grant_o      out  GRANT_W  binary index of locked input (crossbar select)
//  grant_oh_o   out  IN_N     one-hot of locked input; all zero when unlocked
//  grant_vld_o  out  1        output is locked to grant_o
//  xfer_o       out  1        flit transferred this cycle (pop strobe to granted input)
// BEHAVIOUR
//  - Reset: state=IDLE, ptr=0, grant_o=0, grant_oh_o=0, grant_vld_o=0, xfer_o=0.
//  - grant_o, grant_oh_o and grant_vld_o are registered.
//  - xfer_o is combinational:
//      xfer_o = grant_vld_o & req_i[grant_o] & out_rdy_i.
//  - FSM, 2 states:
//    IDLE:   if |req_i, select winner w = first set bit of req_i searching
//            ptr, ptr+1, ..., IN_N-1, 0, ..., ptr-1.
//            Next cycle: LOCKED, grant_o=w, grant_oh_o=1<<w, grant_vld_o=1.
//            If no req, stay IDLE.
//            Arbitration latency is 1 cycle (request to grant_vld_o).
//    LOCKED: on xfer_o with last_i[grant_o]=1, the next cycle is IDLE,
//            grant_vld_o=0, grant_oh_o=0, ptr=(grant_o+1) mod IN_N.
//            grant_o keeps its last value.
//            Otherwise stay LOCKED; grant never changes mid-packet.
//  - One idle bubble cycle always follows a tail transfer. No re-arbitration
//    happens in the release cycle.
//  - Boundary cases:
//    * Granted input drops req_i mid-packet: stay LOCKED, xfer_o=0.
//      Other requesters are ignored.
//    * out_rdy_i=0: xfer_o=0, lock held, last_i ignored.
//    * last_i on a non-granted input, or without req_i: ignored.
//    * Single-flit packet: tail transfers on the first LOCKED cycle with
//      req/last/rdy set; lock lasts 1 cycle.
//    * ptr wrap: grant IN_N-1 released -> ptr=0.
//    * IN_N=1: ptr stays 0, grant_o=0.
//    * Reset while LOCKED: next cycle IDLE with reset values; the packet is abandoned.
//    * ptr only updates on release, never in IDLE.
// TESTING
//  1. Assert rst_i for 2 cycles with req_i=5'b11111
//     -> grant_vld_o=0, grant_oh_o=0, xfer_o=0 throughout and 1 cycle after.
//  2. IN_N=5, req_i=5'b00100, last_i=5'b00100, out_rdy_i=1
//     -> cyc1: grant_o=2, grant_oh_o=5'b00100, xfer_o=1.
//     -> cyc2: grant_vld_o=0. Next winner with all req set is 3.
//  3. req_i=5'b11111 held, last_i=5'b11111, out_rdy_i=1
//     -> grant_o sequence 0,1,2,3,4,0 with a lock every 2 cycles.
//     -> xfer_o=1 on each locked cycle.
//  4. Input 1 sends a 3-flit packet (last_i[1] on the 3rd) while req_i[3]=1 throughout
//     -> grant_o=1 for 3 transfer cycles, then 1 idle cycle, then grant_o=3.
//  5. Locked to input 4, out_rdy_i=0 for 4 cycles, req_i[4]=1, last_i[4]=1
//     -> xfer_o=0, grant held.
//     -> out_rdy_i=1: xfer_o=1, release next cycle, ptr=0.
//  6. rst_i pulsed mid-packet (locked to 2, 1 flit sent)
//     -> next cycle grant_vld_o=0, ptr=0.
//     -> with req_i=5'b00101, next grant is 0.

Source files
------------

// File: rtl/wormhole_output_allocator_if.sv
// Route-request / crossbar-select bundle between the input buffers and one
// output port's allocator.
interface wormhole_output_allocator_if #(
  parameter int IN_N = 5
);
  localparam int GRANT_W = (IN_N > 1) ? $clog2(IN_N) : 1;

  logic [IN_N-1:0]    req;
  logic [IN_N-1:0]    last;
  logic               out_rdy;
  logic [GRANT_W-1:0] grant;
  logic [IN_N-1:0]    grant_oh;
  logic               grant_vld;
  logic               xfer;

  modport master (
    output req, last, out_rdy,
    input  grant, grant_oh, grant_vld, xfer
  );

  modport slave (
    input  req, last, out_rdy,
    output grant, grant_oh, grant_vld, xfer
  );
endinterface

// File: rtl/wormhole_output_allocator.sv
// Per-output wormhole allocator: round-robin pick in IDLE, grant held from
// head flit to tail flit, one bubble cycle after every tail transfer.
module wormhole_output_allocator #(
  parameter int IN_N = 5,
  localparam int GRANT_W = (IN_N > 1) ? $clog2(IN_N) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  wormhole_output_allocator_if.slave  alloc
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [GRANT_W-1:0] ptr_r;
  logic [GRANT_W-1:0] ptr_s;
  logic [GRANT_W-1:0] grant_r;
  logic [GRANT_W-1:0] grant_s;
  logic [IN_N-1:0]    grant_oh_r;
  logic [IN_N-1:0]    grant_oh_s;
  logic               grant_vld_r;
  logic               grant_vld_s;
  logic               xfer_s;
  logic               tail_s;
  logic [GRANT_W:0]   pick_s;

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [GRANT_W:0] pick_winner(
    input logic [IN_N-1:0]    req,
    input logic [GRANT_W-1:0] ptr
  );
    logic               found;
    logic [GRANT_W-1:0] win;
    int                 idx;
    found = 1'b0;
    win   = {GRANT_W{1'b0}};
    for (int i = 0; i < IN_N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= IN_N) begin
        idx = idx - IN_N;
      end
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = GRANT_W'(idx);
      end
    end
    return {found, win};
  endfunction

  // Expands a binary index into a one-hot vector.
  function automatic logic [IN_N-1:0] to_onehot(input logic [GRANT_W-1:0] idx);
    logic [IN_N-1:0] oh;
    for (int i = 0; i < IN_N; i++) begin
      oh[i] = (GRANT_W'(i) == idx);
    end
    return oh;
  endfunction

  // Pop strobe toward the locked input; the registered lock qualifies it.
  always_comb begin
    xfer_s = grant_vld_r & alloc.req[grant_r] & alloc.out_rdy;
    tail_s = xfer_s & alloc.last[grant_r];
    pick_s = pick_winner(alloc.req, ptr_r);
  end

  // Next-state and next-grant logic.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    grant_s     = grant_r;
    grant_oh_s  = grant_oh_r;
    grant_vld_s = grant_vld_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_s[GRANT_W]) begin
          state_s     = ST_LOCKED;
          grant_s     = pick_s[GRANT_W-1:0];
          grant_oh_s  = to_onehot(pick_s[GRANT_W-1:0]);
          grant_vld_s = 1'b1;
        end else begin
          state_s     = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        // grant_r is deliberately kept on release so the crossbar select is stable.
        if (tail_s) begin
          state_s     = ST_IDLE;
          grant_oh_s  = {IN_N{1'b0}};
          grant_vld_s = 1'b0;
          if (grant_r == GRANT_W'(IN_N - 1)) begin
            ptr_s = {GRANT_W{1'b0}};
          end else begin
            ptr_s = grant_r + GRANT_W'(1);
          end
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        grant_oh_s  = {IN_N{1'b0}};
        grant_vld_s = 1'b0;
      end
    endcase
  end

  // State and registered grant outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {GRANT_W{1'b0}};
      grant_r     <= {GRANT_W{1'b0}};
      grant_oh_r  <= {IN_N{1'b0}};
      grant_vld_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      grant_r     <= grant_s;
      grant_oh_r  <= grant_oh_s;
      grant_vld_r <= grant_vld_s;
    end
  end

  assign alloc.grant     = grant_r;
  assign alloc.grant_oh  = grant_oh_r;
  assign alloc.grant_vld = grant_vld_r;
  assign alloc.xfer      = xfer_s;

endmodule

// File: tb/tb_wormhole_output_allocator.sv
// Random and directed stimulus for the wormhole allocator, checked every cycle
// against a packet-level round-robin model.
module tb_wormhole_output_allocator;
  localparam int IN_N = 5;
  localparam int GW   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wormhole_output_allocator_if #(.IN_N(IN_N)) alloc ();

  wormhole_output_allocator #(.IN_N(IN_N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .alloc (alloc)
  );

  int errors = 0;
  int checks = 0;

  // model: which input owns the output (if any) and where the next search starts
  bit m_known  = 1'b0;
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_ptr    = 0;

  logic [GW-1:0]   obs_grant;
  logic [IN_N-1:0] obs_oh;
  logic            obs_vld;
  logic            obs_xfer;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // one clock cycle: drive, sample at negedge, check, advance model
  task automatic cycle(input logic r, input logic [IN_N-1:0] rq, input logic [IN_N-1:0] lt,
                       input logic rd);
    logic            exp_x;
    logic [IN_N-1:0] exp_oh;
    rst           = r;
    alloc.req     = rq;
    alloc.last    = lt;
    alloc.out_rdy = rd;
    @(negedge clk);
    obs_grant = alloc.grant;
    obs_oh    = alloc.grant_oh;
    obs_vld   = alloc.grant_vld;
    obs_xfer  = alloc.xfer;
    exp_x  = m_locked && rq[m_owner] && rd;
    exp_oh = m_locked ? IN_N'(1 << m_owner) : {IN_N{1'b0}};
    if (m_known) begin
      check_eq("grant_vld", 32'(obs_vld), 32'(m_locked));
      check_eq("grant_oh", 32'(obs_oh), 32'(exp_oh));
      check_eq("grant", 32'(obs_grant), 32'(m_owner));
      check_eq("xfer", 32'(obs_xfer), 32'(exp_x));
    end
    if (r) begin
      m_known  = 1'b1;
      m_locked = 1'b0;
      m_owner  = 0;
      m_ptr    = 0;
    end else if (!m_locked) begin
      for (int k = 0; k < IN_N; k++) begin
        if (rq[(m_ptr + k) % IN_N]) begin
          m_owner  = (m_ptr + k) % IN_N;
          m_locked = 1'b1;
          break;
        end
      end
    end else if (exp_x && lt[m_owner]) begin
      m_locked = 1'b0;
      m_ptr    = (m_owner + 1) % IN_N;
    end
    @(posedge clk);
    #1;
  endtask

  int exp_seq[6] = '{0, 1, 2, 3, 4, 0};
  int seq_n;

  initial begin
    rst = 1'b1;
    alloc.req = '0; alloc.last = '0; alloc.out_rdy = 1'b0;
    @(posedge clk); #1;

    // reset held 2 cycles with every input requesting
    cycle(1'b1, 5'b11111, 5'b11111, 1'b1);
    cycle(1'b1, 5'b11111, 5'b11111, 1'b1);
    check_eq("rst_vld", 32'(obs_vld), 32'd0);
    check_eq("rst_oh", 32'(obs_oh), 32'd0);
    check_eq("rst_xfer", 32'(obs_xfer), 32'd0);
    cycle(1'b0, 5'b11111, 5'b11111, 1'b1);
    check_eq("post_rst_vld", 32'(obs_vld), 32'd0);

    // single-flit packet from input 2, next winner 3
    cycle(1'b1, 5'b00000, 5'b00000, 1'b1);
    cycle(1'b0, 5'b00100, 5'b00100, 1'b1);
    cycle(1'b0, 5'b00100, 5'b00100, 1'b1);
    check_eq("t2_grant", 32'(obs_grant), 32'd2);
    check_eq("t2_oh", 32'(obs_oh), 32'b00100);
    check_eq("t2_xfer", 32'(obs_xfer), 32'd1);
    cycle(1'b0, 5'b11111, 5'b11111, 1'b1);
    check_eq("t2_bubble", 32'(obs_vld), 32'd0);
    cycle(1'b0, 5'b11111, 5'b11111, 1'b1);
    check_eq("t2_next", 32'(obs_grant), 32'd3);

    // all requesting single-flit: round-robin every 2 cycles
    cycle(1'b1, 5'b00000, 5'b00000, 1'b1);
    seq_n = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, 5'b11111, 5'b11111, 1'b1);
      check_eq("t3_vld", 32'(obs_vld), 32'(c % 2));
      if (obs_vld && seq_n < 6) begin
        check_eq("t3_seq", 32'(obs_grant), 32'(exp_seq[seq_n]));
        check_eq("t3_xfer", 32'(obs_xfer), 32'd1);
        seq_n++;
      end
    end
    check_eq("t3_count", 32'(seq_n), 32'd6);

    // 3-flit packet from input 1 with input 3 waiting
    cycle(1'b1, 5'b00000, 5'b00000, 1'b1);
    cycle(1'b0, 5'b01010, 5'b00000, 1'b1);
    cycle(1'b0, 5'b01010, 5'b00000, 1'b1);
    check_eq("t4_f1", 32'(obs_grant), 32'd1);
    cycle(1'b0, 5'b01010, 5'b00000, 1'b1);
    check_eq("t4_f2", 32'(obs_grant), 32'd1);
    cycle(1'b0, 5'b01010, 5'b00010, 1'b1);
    check_eq("t4_f3", 32'(obs_xfer), 32'd1);
    cycle(1'b0, 5'b01000, 5'b00000, 1'b1);
    check_eq("t4_bubble", 32'(obs_vld), 32'd0);
    cycle(1'b0, 5'b01000, 5'b00000, 1'b1);
    check_eq("t4_next", 32'(obs_grant), 32'd3);

    // backpressure while locked to input 4, then wrap ptr to 0
    cycle(1'b1, 5'b00000, 5'b00000, 1'b0);
    cycle(1'b0, 5'b10000, 5'b10000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 5'b10000, 5'b10000, 1'b0);
      check_eq("t5_hold_x", 32'(obs_xfer), 32'd0);
      check_eq("t5_hold_g", 32'(obs_grant), 32'd4);
    end
    cycle(1'b0, 5'b10000, 5'b10000, 1'b1);
    check_eq("t5_xfer", 32'(obs_xfer), 32'd1);
    cycle(1'b0, 5'b10001, 5'b00000, 1'b1);
    check_eq("t5_bubble", 32'(obs_vld), 32'd0);
    cycle(1'b0, 5'b10001, 5'b00000, 1'b1);
    check_eq("t5_wrap", 32'(obs_grant), 32'd0);

    // reset mid-packet abandons the lock
    cycle(1'b1, 5'b00000, 5'b00000, 1'b1);
    cycle(1'b0, 5'b00100, 5'b00000, 1'b1);
    cycle(1'b0, 5'b00100, 5'b00000, 1'b1);
    check_eq("t6_flit", 32'(obs_xfer), 32'd1);
    cycle(1'b1, 5'b00100, 5'b00000, 1'b1);
    cycle(1'b0, 5'b00101, 5'b00000, 1'b1);
    check_eq("t6_vld", 32'(obs_vld), 32'd0);
    cycle(1'b0, 5'b00101, 5'b00000, 1'b1);
    check_eq("t6_grant", 32'(obs_grant), 32'd0);

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      cycle(($urandom_range(99) == 0) ? 1'b1 : 1'b0,
            IN_N'($urandom), IN_N'($urandom),
            ($urandom_range(3) != 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
